// File: rtl/disp_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GUARD,
        SHOW
    } scan_state_t;

    localparam logic [6:0]  SEG_BLANK  = 7'h7F;
    localparam int unsigned MAX_DIGITS = 8;

    // True when every populated nibble at index `from` and above is zero.
    function automatic logic upper_nibbles_zero(
        input logic [31:0]  v,
        input logic [2:0]   from,
        input int unsigned  ndig
    );
        logic z;
        z = 1'b1;
        for (int unsigned j = 0; j < MAX_DIGITS; j++) begin
            if (j >= 32'(from) && j < ndig && 4'(v >> (4 * j)) != 4'h0) begin
                z = 1'b0;
            end
        end
        return z;
    endfunction

endpackage

// File: rtl/hex_seg_lut.sv
// Hex nibble to active-low seven-segment glyph {g,f,e,d,c,b,a}.
module hex_seg_lut
    import disp_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_n_o
);

    always_comb begin
        seg_n_o = SEG_BLANK;
        case (nibble_i)
            4'h0: seg_n_o = 7'h40;
            4'h1: seg_n_o = 7'h79;
            4'h2: seg_n_o = 7'h24;
            4'h3: seg_n_o = 7'h30;
            4'h4: seg_n_o = 7'h19;
            4'h5: seg_n_o = 7'h12;
            4'h6: seg_n_o = 7'h02;
            4'h7: seg_n_o = 7'h78;
            4'h8: seg_n_o = 7'h00;
            4'h9: seg_n_o = 7'h10;
            4'hA: seg_n_o = 7'h08;
            4'hB: seg_n_o = 7'h03;
            4'hC: seg_n_o = 7'h46;
            4'hD: seg_n_o = 7'h21;
            4'hE: seg_n_o = 7'h06;
            4'hF: seg_n_o = 7'h0E;
            default: seg_n_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Multiplexed common-anode display scanner: one digit per slot, guard gap,
// shadow value committed only at frame boundaries, all pins registered.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned GUARD_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [31:0]           value,
    input  logic                  blank_lz,
    output logic [6:0]            seg_n,
    output logic [NUM_DIGITS-1:0] digit_n,
    output logic [2:0]            digit_idx,
    output logic                  frame_start,
    output logic                  load_ack
);

    localparam int unsigned    CW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]  CNT_GUARD = CW'(GUARD_CYCLES);
    localparam logic [2:0]     IDX_LAST  = 3'(NUM_DIGITS - 1);

    scan_state_t           state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [2:0]            idx_q, idx_d;
    logic [31:0]           shadow_q, shadow_d;
    logic [31:0]           pending_q, pending_d;
    logic                  pend_valid_q, pend_valid_d;
    logic                  blank_q, blank_d;
    logic [6:0]            seg_n_q, seg_n_d;
    logic [NUM_DIGITS-1:0] digit_n_q, digit_n_d;
    logic                  frame_start_q, frame_start_d;
    logic                  load_ack_q, load_ack_d;

    logic                  commit;
    logic                  slot_entry;
    logic [3:0]            nibble;
    logic [6:0]            lut_seg;

    // Sequencing: slot counter, digit index, frame boundary and commit point.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        frame_start_d = 1'b0;
        slot_entry    = 1'b0;
        commit        = 1'b0;

        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            commit  = (state_q == IDLE) && (load || pend_valid_q);
        end else if (state_q == IDLE) begin
            cnt_d         = '0;
            idx_d         = '0;
            slot_entry    = 1'b1;
            frame_start_d = 1'b1;
            commit        = load || pend_valid_q;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d      = '0;
            slot_entry = 1'b1;
            if (idx_q == IDX_LAST) begin
                idx_d         = '0;
                frame_start_d = 1'b1;
                commit        = load || pend_valid_q;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        // Guard occupies the first GUARD_CYCLES counts of every slot.
        if (enable) begin
            state_d = (cnt_d < CNT_GUARD) ? GUARD : SHOW;
        end
    end

    always_comb begin
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        pend_valid_d = pend_valid_q;
        load_ack_d   = commit;

        if (commit) begin
            shadow_d     = load ? value : pending_q;
            pend_valid_d = 1'b0;
        end else if (load) begin
            pending_d    = value;
            pend_valid_d = 1'b1;
        end

        blank_d = blank_q;
        if (slot_entry) begin
            blank_d = blank_lz && (idx_d != 3'd0)
                      && upper_nibbles_zero(shadow_d, idx_d, NUM_DIGITS);
        end

        nibble = shadow_d[{idx_d, 2'b00} +: 4];
    end

    hex_seg_lut u_lut (
        .nibble_i (nibble),
        .seg_n_o  (lut_seg)
    );

    // Pins are computed from next-state so they change on the same edge as state.
    always_comb begin
        digit_n_d = '1;
        seg_n_d   = SEG_BLANK;
        if (state_d == SHOW && !blank_d) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (idx_d == 3'(i)) begin
                    digit_n_d[i] = 1'b0;
                    seg_n_d      = lut_seg;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            shadow_q      <= '0;
            pending_q     <= '0;
            pend_valid_q  <= 1'b0;
            blank_q       <= 1'b0;
            seg_n_q       <= SEG_BLANK;
            digit_n_q     <= '1;
            frame_start_q <= 1'b0;
            load_ack_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            pending_q     <= pending_d;
            pend_valid_q  <= pend_valid_d;
            blank_q       <= blank_d;
            seg_n_q       <= seg_n_d;
            digit_n_q     <= digit_n_d;
            frame_start_q <= frame_start_d;
            load_ack_q    <= load_ack_d;
        end
    end

    assign seg_n       = seg_n_q;
    assign digit_n     = digit_n_q;
    assign digit_idx   = idx_q;
    assign frame_start = frame_start_q;
    assign load_ack    = load_ack_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench for disp_scan_ctrl with a 4-digit, 8-cycle-slot, 2-cycle-guard setup.
module tb_disp_scan_ctrl;

    localparam int unsigned ND = 4;
    localparam int unsigned RD = 8;
    localparam int unsigned GC = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          load;
    logic [31:0]   value;
    logic          blank_lz;
    logic [6:0]    seg_n;
    logic [ND-1:0] digit_n;
    logic [2:0]    digit_idx;
    logic          frame_start;
    logic          load_ack;

    typedef struct {
        logic [15:0] w;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_chk = 0;
    int unsigned n_bad = 0;

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    disp_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .GUARD_CYCLES (GC)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .load        (load),
        .value       (value),
        .blank_lz    (blank_lz),
        .seg_n       (seg_n),
        .digit_n     (digit_n),
        .digit_idx   (digit_idx),
        .frame_start (frame_start),
        .load_ack    (load_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] obs_word();
        return {frame_start, load_ack, digit_idx, digit_n, seg_n};
    endfunction

    function automatic logic [15:0] idle_word(input logic la);
        return {1'b0, la, 3'd0, 4'hF, 7'h7F};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected pins for frame cycles c0..c1, cycle 0 being the slot-0 entry edge.
    task automatic push_frame(input logic [31:0] v, input logic ack, input logic blz,
                              input int unsigned c0, input int unsigned c1, input string nm);
        exp_t        e;
        int unsigned s;
        int unsigned k;
        logic [3:0]  dn;
        logic [6:0]  sg;
        logic [15:0] low;
        logic        blank;
        for (int unsigned c = c0; c <= c1; c++) begin
            s     = c / RD;
            k     = c % RD;
            low   = v[15:0];
            blank = blz && (s != 0) && ((low >> (4 * s)) == 16'h0);
            dn    = 4'hF;
            sg    = 7'h7F;
            if (k >= GC && !blank) begin
                dn[s] = 1'b0;
                sg    = glyph[4'(low >> (4 * s))];
            end
            e.w   = {(c == 0), (c == 0) && ack, 3'(s), dn, sg};
            e.tag = $sformatf("%s_c%0d", nm, c);
            sb.push_back(e);
        end
    endtask

    task automatic push_idle(input logic la, input string nm);
        exp_t e;
        e.w   = idle_word(la);
        e.tag = nm;
        sb.push_back(e);
    endtask

    task automatic tick(input int unsigned n);
        exp_t e;
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.tag, 32'(obs_word()), 32'(e.w));
            end
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        enable   = 1'b0;
        load     = 1'b0;
        value    = '0;
        blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_pins", 32'(obs_word()), 32'(idle_word(1'b0)));
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", 32'(obs_word()), 32'(idle_word(1'b0)));

        // 1: enable with a simultaneous load commits on slot-0 entry.
        enable = 1'b1; load = 1'b1; value = 32'h1234;
        push_frame(32'h1234, 1'b1, 1'b0, 0, 31, "t1");
        tick(1);
        load = 1'b0;
        tick(31);

        // 2: two loads inside one frame; only the latest shows, next frame.
        push_frame(32'h1234, 1'b0, 1'b0, 0, 31, "t2a");
        tick(10);
        load = 1'b1; value = 32'hABCD; tick(1);
        load = 1'b0; tick(9);
        load = 1'b1; value = 32'h0F0F; tick(1);
        load = 1'b0; tick(11);
        push_frame(32'h0F0F, 1'b1, 1'b0, 0, 31, "t2b");
        tick(32);

        // 3: leading-zero blanking of a staged value.
        push_frame(32'h0F0F, 1'b0, 1'b0, 0, 31, "t3a");
        tick(5);
        load = 1'b1; value = 32'h0000_0050; tick(1);
        load = 1'b0; tick(26);
        blank_lz = 1'b1;
        push_frame(32'h0000_0050, 1'b1, 1'b1, 0, 31, "t3b");
        tick(32);

        // 4: load exactly on the slot-0 entry edge bypasses pending.
        blank_lz = 1'b0; load = 1'b1; value = 32'h0007;
        push_frame(32'h0007, 1'b1, 1'b0, 0, 31, "t4");
        tick(1);
        load = 1'b0;
        tick(31);

        // 5: drop enable during SHOW of digit 2, commit while idle, restart.
        push_frame(32'h0007, 1'b0, 1'b0, 0, 19, "t5a");
        tick(20);
        enable = 1'b0;
        push_idle(1'b0, "t5_off0"); tick(1);
        push_idle(1'b0, "t5_off1"); tick(1);
        load = 1'b1; value = 32'h9;
        push_idle(1'b1, "t5_idle_ack"); tick(1);
        load = 1'b0;
        push_idle(1'b0, "t5_idle_noack"); tick(1);
        enable = 1'b1;
        push_frame(32'h9, 1'b0, 1'b0, 0, 31, "t5b");
        tick(32);

        // 6: async reset mid-slot with a load pending.
        push_frame(32'h9, 1'b0, 1'b0, 0, 11, "t6a");
        tick(12);
        load = 1'b1; value = 32'hDEAD;
        push_frame(32'h9, 1'b0, 1'b0, 12, 12, "t6a");
        tick(1);
        load = 1'b0;
        #2;
        reset_n = 1'b0;
        enable  = 1'b0;
        #1;
        chk("t6_async_off", 32'(obs_word()), 32'(idle_word(1'b0)));
        @(negedge clk);
        reset_n = 1'b1;
        push_idle(1'b0, "t6_idle"); tick(1);
        enable = 1'b1;
        push_frame(32'h0, 1'b0, 1'b0, 0, 31, "t6b");
        tick(32);

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
